// File: rtl/brick_arbiter_pkg.sv
// Shared constants and FSM encoding for the brick-strength RAM arbiter.
// The game controller and brick renderer import the same constants.
package brick_arbiter_pkg;

    localparam int BALL_NUM  = 3;
    localparam int BRICK_NUM = 128;
    localparam int ADDR_W    = 7;
    localparam int STR_W     = 2;

    localparam logic [STR_W-1:0] STR_EMPTY = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/brick_arbiter_if.sv
// Ball-request and brick-RAM signal bundle; names are relative to the arbiter.
// slave is the arbiter side, master is the requester/RAM side.
interface brick_arbiter_if #(
    parameter int BALL_NUM = brick_arbiter_pkg::BALL_NUM,
    parameter int ADDR_W   = brick_arbiter_pkg::ADDR_W,
    parameter int STR_W    = brick_arbiter_pkg::STR_W
);
    import brick_arbiter_pkg::*;

    logic [BALL_NUM-1:0]        i_req;
    logic [BALL_NUM*ADDR_W-1:0] i_req_addr;
    logic [BALL_NUM-1:0]        o_ack;
    logic                       o_ack_hit;
    logic                       o_destroyed;
    logic                       o_busy;
    logic [ADDR_W-1:0]          o_mem_addr;
    logic                       o_mem_en;
    logic                       o_mem_we;
    logic [STR_W-1:0]           o_mem_wdata;
    logic [STR_W-1:0]           i_mem_rdata;

    modport slave (
        input  i_req,
        input  i_req_addr,
        input  i_mem_rdata,
        output o_ack,
        output o_ack_hit,
        output o_destroyed,
        output o_busy,
        output o_mem_addr,
        output o_mem_en,
        output o_mem_we,
        output o_mem_wdata
    );

    modport master (
        output i_req,
        output i_req_addr,
        output i_mem_rdata,
        input  o_ack,
        input  o_ack_hit,
        input  o_destroyed,
        input  o_busy,
        input  o_mem_addr,
        input  o_mem_en,
        input  o_mem_we,
        input  o_mem_wdata
    );

endinterface

// File: rtl/brick_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_rr_ptr,
// scanning upward with wrap-around.
module rr_arbiter #(
    parameter  int BALL_NUM = brick_arbiter_pkg::BALL_NUM,
    localparam int IDX_W    = brick_arbiter_pkg::idx_w(BALL_NUM)
) (
    input  logic [BALL_NUM-1:0] i_req,
    input  logic [IDX_W-1:0]    i_rr_ptr,
    output logic                o_gnt_valid,
    output logic [IDX_W-1:0]    o_gnt_idx
);
    import brick_arbiter_pkg::*;

    localparam logic [IDX_W:0] NUM = (IDX_W+1)'(BALL_NUM);

    logic [IDX_W:0]      w_sum  [BALL_NUM];
    logic [IDX_W:0]      w_wrap [BALL_NUM];
    logic [IDX_W-1:0]    w_cand [BALL_NUM];
    logic [BALL_NUM-1:0] w_hit;

    // Candidate gi is the requester sitting gi places after the pointer.
    generate
        for (genvar gi = 0; gi < BALL_NUM; gi++) begin : g_cand
            assign w_sum[gi]  = {1'b0, i_rr_ptr} + (IDX_W+1)'(gi);
            assign w_wrap[gi] = (w_sum[gi] >= NUM) ? (w_sum[gi] - NUM) : w_sum[gi];
            assign w_cand[gi] = w_wrap[gi][IDX_W-1:0];
            assign w_hit[gi]  = i_req[w_cand[gi]];
        end
    endgenerate

    // Scanning downward lets the nearest candidate overwrite farther ones.
    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        for (int k = BALL_NUM - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_cand[k];
            end
        end
    end

endmodule

// File: rtl/brick_arbiter.sv
// Serialises ball collision requests into read-check-decrement transactions
// on the single-port brick-strength RAM, acking each ball with a hit flag.
module brick_arbiter #(
    parameter int BALL_NUM  = brick_arbiter_pkg::BALL_NUM,
    parameter int BRICK_NUM = brick_arbiter_pkg::BRICK_NUM,
    parameter int ADDR_W    = brick_arbiter_pkg::ADDR_W,
    parameter int STR_W     = brick_arbiter_pkg::STR_W
) (
    input  logic           clk,
    input  logic           rst,
    brick_arbiter_if.slave bus
);
    import brick_arbiter_pkg::*;

    localparam int               IDX_W    = idx_w(BALL_NUM);
    localparam logic [ADDR_W:0]  LIMIT    = (ADDR_W+1)'(BRICK_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BALL_NUM - 1);
    localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);

    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_gnt_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_hit;
    logic                r_destroyed;

    logic                w_gnt_valid;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic [ADDR_W-1:0]   w_addr_arr [BALL_NUM];
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic                w_gnt_in_range;
    logic                w_rdata_nz;
    logic [BALL_NUM-1:0] w_ack_vec;

    rr_arbiter #(
        .BALL_NUM (BALL_NUM)
    ) u_rr_arbiter (
        .i_req       (bus.i_req),
        .i_rr_ptr    (r_rr_ptr),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    generate
        for (genvar gi = 0; gi < BALL_NUM; gi++) begin : g_ball
            assign w_addr_arr[gi] = bus.i_req_addr[gi*ADDR_W +: ADDR_W];
            assign w_ack_vec[gi]  = (r_gnt_idx == IDX_W'(gi));
        end
    endgenerate

    assign w_gnt_addr     = w_addr_arr[w_gnt_idx];
    assign w_gnt_in_range = ({1'b0, w_gnt_addr} < LIMIT);
    assign w_rdata_nz     = (bus.i_mem_rdata != STR_EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Out-of-range addresses skip the RAM entirely and ack as a miss.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_next = w_gnt_in_range ? ST_READ : ST_ACK;
                end
            end
            ST_READ:  w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = ST_ACK;
            ST_ACK:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.o_ack       = '0;
        bus.o_ack_hit   = 1'b0;
        bus.o_mem_addr  = '0;
        bus.o_mem_en    = 1'b0;
        bus.o_mem_we    = 1'b0;
        bus.o_mem_wdata = '0;
        case (r_state)
            ST_READ: begin
                bus.o_mem_en   = 1'b1;
                bus.o_mem_addr = r_addr;
            end
            ST_CHECK: begin
                bus.o_mem_addr = r_addr;
                if (w_rdata_nz) begin
                    bus.o_mem_we    = 1'b1;
                    bus.o_mem_wdata = bus.i_mem_rdata - STR_ONE;
                end
            end
            ST_ACK: begin
                bus.o_ack     = w_ack_vec;
                bus.o_ack_hit = r_hit;
            end
            default: begin
            end
        endcase
    end

    assign bus.o_busy      = (r_state != ST_IDLE);
    assign bus.o_destroyed = r_destroyed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_gnt_idx   <= '0;
            r_addr      <= '0;
            r_hit       <= 1'b0;
            r_destroyed <= 1'b0;
        end else begin
            // Only ever high for the single ACK cycle that follows CHECK.
            r_destroyed <= (r_state == ST_CHECK) && (bus.i_mem_rdata == STR_ONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt_idx <= w_gnt_idx;
                        r_addr    <= w_gnt_addr;
                        r_hit     <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_hit <= w_rdata_nz;
                end
                ST_ACK: begin
                    r_rr_ptr <= (r_gnt_idx == LAST_IDX) ? '0 : (r_gnt_idx + IDX_W'(1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_brick_arbiter.sv
// Randomised and directed bench for brick_arbiter: a transaction-level model
// predicts each grant and pushes the expected ack; a monitor pops and compares.
module tb_brick_arbiter;

    localparam int NB = 3;
    localparam int BN = 120;
    localparam int AW = 7;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    brick_arbiter_if #(.BALL_NUM(NB), .ADDR_W(AW), .STR_W(SW)) bus ();

    brick_arbiter #(
        .BALL_NUM  (NB),
        .BRICK_NUM (BN),
        .ADDR_W    (AW),
        .STR_W     (SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NB-1:0] req_drv = '0;
    logic [AW-1:0] addr_drv [NB];
    logic [NB-1:0] last_ack;

    assign bus.i_req = req_drv;
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_addr
            assign bus.i_req_addr[gi*AW +: AW] = addr_drv[gi];
        end
    endgenerate

    // Brick RAM with registered read; load_en copies the preload pattern.
    logic [SW-1:0] ram      [128];
    logic [SW-1:0] init_pat [128];
    logic          load_en = 1'b0;
    logic [SW-1:0] rdata_r = '0;
    assign bus.i_mem_rdata = rdata_r;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_pat[i];
        end else begin
            if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
            if (bus.o_mem_en) rdata_r <= ram[bus.o_mem_addr];
        end
    end

    typedef struct {
        int          ball;
        logic [AW-1:0] addr;
        bit          inr;
        bit          hit;
        bit          destr;
        logic [SW-1:0] wdata;
        int          cyc;
    } exp_t;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input bit ok, input string got, input string want);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %s, want %s", name, got, want);
        end
    endtask

    // Transaction-level model: a grant costs 4 cycles in range, 2 out of range.
    int   cyc = 0;
    int   m_ready = 0;
    int   m_busy_until = -1;
    int   m_rr = 0;
    int   m_wr_cyc = -1;
    int   m_undo_addr = 0;
    int   m_undo_val = 0;
    bit   m_undo = 1'b0;
    int   m_ram [128];
    int   m_b;
    int   m_s;
    exp_t m_e;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (load_en) begin
                for (int i = 0; i < 128; i++) m_ram[i] = int'(init_pat[i]);
            end
            if (rst) begin
                exp_q.delete();
                if (m_undo && cyc <= m_wr_cyc) m_ram[m_undo_addr] = m_undo_val;
                m_undo       = 1'b0;
                m_rr         = 0;
                m_ready      = cyc + 1;
                m_busy_until = -1;
            end else if (cyc >= m_ready && req_drv != '0) begin
                m_b = -1;
                for (int k = 0; k < NB; k++) begin
                    if (m_b < 0 && req_drv[(m_rr + k) % NB]) m_b = (m_rr + k) % NB;
                end
                m_e.ball = m_b;
                m_e.addr = addr_drv[m_b];
                m_e.inr  = (int'(addr_drv[m_b]) < BN);
                m_undo   = 1'b0;
                if (!m_e.inr) begin
                    m_e.hit      = 1'b0;
                    m_e.destr    = 1'b0;
                    m_e.wdata    = '0;
                    m_e.cyc      = cyc;
                    m_busy_until = cyc;
                    m_ready      = cyc + 2;
                end else begin
                    m_s       = m_ram[m_e.addr];
                    m_e.hit   = (m_s > 0);
                    m_e.destr = (m_s == 1);
                    m_e.wdata = m_e.hit ? SW'(m_s - 1) : '0;
                    if (m_e.hit) begin
                        m_undo        = 1'b1;
                        m_undo_addr   = int'(m_e.addr);
                        m_undo_val    = m_s;
                        m_wr_cyc      = cyc + 2;
                        m_ram[m_e.addr] = m_s - 1;
                    end
                    m_e.cyc      = cyc + 2;
                    m_busy_until = cyc + 2;
                    m_ready      = cyc + 4;
                end
                m_rr = (m_b + 1) % NB;
                exp_q.push_back(m_e);
            end
        end
    end

    // Monitor: compares DUT outputs against the head of the expectation queue.
    exp_t          mon_e;
    logic [NB-1:0] mon_want;
    bit            mon_ok;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy", bus.o_busy == (cyc <= m_busy_until),
                      $sformatf("%0b", bus.o_busy), $sformatf("%0b", cyc <= m_busy_until));
                if (bus.o_mem_en) begin
                    mon_ok = exp_q.size() > 0;
                    if (mon_ok) mon_ok = exp_q[0].inr && cyc == exp_q[0].cyc - 2 &&
                                         bus.o_mem_addr == exp_q[0].addr;
                    check("mem_en", mon_ok, $sformatf("en addr=%0d cyc=%0d", bus.o_mem_addr, cyc),
                          "read of the granted in-range address two cycles before ack");
                end
                if (bus.o_mem_we) begin
                    mon_ok = exp_q.size() > 0;
                    if (mon_ok) mon_ok = exp_q[0].hit && cyc == exp_q[0].cyc - 1 &&
                                         bus.o_mem_addr == exp_q[0].addr &&
                                         bus.o_mem_wdata == exp_q[0].wdata;
                    check("mem_we", mon_ok,
                          $sformatf("we addr=%0d wdata=%0d cyc=%0d", bus.o_mem_addr, bus.o_mem_wdata, cyc),
                          "decrement write of a hit one cycle before ack");
                end
                if (bus.o_ack != '0) begin
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", 1'b0, $sformatf("ack=%b", bus.o_ack), "no ack");
                    end else begin
                        mon_e    = exp_q.pop_front();
                        mon_want = '0;
                        mon_want[mon_e.ball] = 1'b1;
                        $display("ack ball=%0d addr=%0d hit=%0b destroyed=%0b cyc=%0d",
                                 mon_e.ball, mon_e.addr, bus.o_ack_hit, bus.o_destroyed, cyc);
                        check("ack", bus.o_ack == mon_want && bus.o_ack_hit == mon_e.hit &&
                                     bus.o_destroyed == mon_e.destr && cyc == mon_e.cyc,
                              $sformatf("ack=%b hit=%0b destr=%0b cyc=%0d", bus.o_ack,
                                        bus.o_ack_hit, bus.o_destroyed, cyc),
                              $sformatf("ack=%b hit=%0b destr=%0b cyc=%0d", mon_want,
                                        mon_e.hit, mon_e.destr, mon_e.cyc));
                    end
                end else begin
                    check("quiet", !bus.o_ack_hit && !bus.o_destroyed,
                          $sformatf("hit=%0b destr=%0b", bus.o_ack_hit, bus.o_destroyed), "0 0");
                    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                        mon_e = exp_q.pop_front();
                        check("ack_missing", 1'b0, "no ack",
                              $sformatf("ack for ball %0d at cyc %0d", mon_e.ball, mon_e.cyc));
                    end
                end
            end
        end
    end

    function automatic bit outs_zero();
        return bus.o_ack == '0 && !bus.o_ack_hit && !bus.o_destroyed && !bus.o_busy &&
               !bus.o_mem_en && !bus.o_mem_we && bus.o_mem_addr == '0 && bus.o_mem_wdata == '0;
    endfunction

    // Requesters drop req on the cycle they observe their ack.
    task automatic tick();
        @(negedge clk);
        last_ack = bus.o_ack;
        for (int b = 0; b < NB; b++) begin
            if (last_ack[b]) req_drv[b] = 1'b0;
        end
    endtask

    task automatic raise(input int b, input int a);
        req_drv[b]  = 1'b1;
        addr_drv[b] = AW'(a);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (req_drv != '0 && k < budget) begin
            tick();
            k++;
        end
        check(name, req_drv == '0, $sformatf("req=%b after %0d cycles", req_drv, k), "all served");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", outs_zero(), "nonzero outputs", "all outputs 0");
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    bit again;

    initial begin
        for (int i = 0; i < 128; i++) init_pat[i] = SW'($urandom_range(0, 3));
        init_pat[5]  = 2'd2;
        init_pat[9]  = 2'd1;
        init_pat[20] = 2'd3;
        init_pat[21] = 2'd1;
        init_pat[22] = 2'd0;
        init_pat[23] = 2'd2;
        init_pat[30] = 2'd2;
        for (int b = 0; b < NB; b++) addr_drv[b] = '0;
        last_ack = '0;

        repeat (3) @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        check("reset_state", outs_zero(), "nonzero outputs", "all outputs 0");
        rst = 1'b0;
        tick();

        // Single hit, then destroy and repeat-miss on the same brick.
        raise(0, 5);
        wait_done(20, "hit_done");
        tick();
        raise(1, 9);
        wait_done(20, "destroy_done");
        tick();
        raise(1, 9);
        wait_done(20, "repeat_done");

        // Contention from a fresh pointer, ball 0 re-requesting immediately.
        do_reset();
        raise(0, 20);
        raise(1, 21);
        raise(2, 22);
        again = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (!again && last_ack[0]) begin
                raise(0, 23);
                again = 1'b1;
            end
            if (again && req_drv == '0) break;
        end
        check("contention_done", again && req_drv == '0, $sformatf("req=%b", req_drv), "all served");

        raise(2, 127);
        wait_done(10, "oor_done");
        tick();

        // Reset landing in CHECK must cancel the write and the ack.
        raise(0, 30);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.o_mem_we) break;
        end
        check("reach_check", bus.o_mem_we == 1'b1, $sformatf("%0b", bus.o_mem_we), "1");
        #1 rst = 1'b1;
        #1 check("rst_midop_outputs", outs_zero(), "nonzero outputs", "all outputs 0");
        tick();
        tick();
        check("rst_ram_kept", ram[30] == 2'd2, $sformatf("%0d", ram[30]), "2");
        rst = 1'b0;
        wait_done(20, "rereq_done");
        tick();

        // A request glitch that never spans a rising edge.
        @(negedge clk);
        req_drv[1] = 1'b1;
        #1 req_drv[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("withdraw_busy", !bus.o_busy, $sformatf("%0b", bus.o_busy), "0");
        end

        for (int n = 0; n < 400; n++) begin
            tick();
            for (int b = 0; b < NB; b++) begin
                if (!req_drv[b] && $urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 7) == 0) raise(b, int'($urandom_range(BN, 127)));
                    else raise(b, int'($urandom_range(0, 15)));
                end
            end
        end
        wait_done(100, "drain");
        repeat (3) tick();
        check("queue_drained", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");

        for (int i = 0; i < BN; i++) begin
            check($sformatf("ram[%0d]", i), int'(ram[i]) == m_ram[i],
                  $sformatf("%0d", ram[i]), $sformatf("%0d", m_ram[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/brick_arbiter.md
# brick_arbiter

Round-robin arbiter that shares the single-port brick-strength RAM among the ball movers. Each ball raises a collision request with a brick address. The arbiter serialises the requests into read-check-decrement transactions on the RAM and returns a one-cycle acknowledge with a hit flag. It sits between the per-ball motion/bounce logic in the game state controller and the brick memory, and also emits a destroy pulse for the score counter.

## Interface
- BALL_NUM, 3, number of requesters (ball movers)
- BRICK_NUM, 128, number of brick slots (16 columns x 8 rows)
- ADDR_W, 7, brick address width, ceil(log2(BRICK_NUM))
- STR_W, 2, brick strength width; 0 means empty
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  BALL_NUM  per-ball collision request, level, held until ack
- req_addr  in  BALL_NUM*ADDR_W  packed brick addresses; ball i in bits [i*ADDR_W +: ADDR_W]
- ack  out  BALL_NUM  one-hot, one-cycle acknowledge to the granted ball
- ack_hit  out  1  valid with ack; 1 = a brick was present and got decremented
- destroyed  out  1  one-cycle pulse when a brick's strength goes 1 -> 0
- busy  out  1  high in every state except IDLE
- mem_addr  out  ADDR_W  brick RAM address
- mem_en  out  1  RAM read enable
- mem_we  out  1  RAM write enable
- mem_wdata  out  STR_W  write data (strength - 1)
- mem_rdata  in  STR_W  read data, valid one cycle after mem_en

## Operation
- FSM states: IDLE, READ, CHECK, ACK.
- IDLE:
  - If any req bit is high, grant the first requester at or after rr_ptr, scanning in increasing index with wrap-around.
  - Latch the granted index into gnt_idx and its address into addr_q.
  - If addr_q >= BRICK_NUM, go straight to ACK with hit_q = 0 and do not access the RAM. Otherwise go to READ.
  - If no req bit is high, stay in IDLE.
- READ: mem_en = 1, mem_addr = addr_q; go to CHECK.
- CHECK: sample mem_rdata.
  - Nonzero: mem_we = 1, mem_addr = addr_q, mem_wdata = mem_rdata - 1, hit_q = 1. If mem_rdata == 1, set destroyed for the following cycle.
  - Zero: no write, hit_q = 0.
  - In both cases go to ACK.
- ACK: ack[gnt_idx] = 1, ack_hit = hit_q, destroyed driven from its register. rr_ptr = (gnt_idx + 1) mod BALL_NUM. Go to IDLE.
- Requester rule: a ball holds req and its address stable until it sees ack, then deasserts req on that same edge. A req still high in the IDLE cycle after ACK is treated as a new request.
- Simultaneous requests: exactly one is granted; the others wait, with no loss and no reordering beyond the round-robin order.
- Request withdrawn before grant: ignored, no side effects. A request withdrawn after grant still completes, and its ack is generated anyway.
- Arithmetic: the decrement never underflows because the zero case never writes. rr_ptr wraps from BALL_NUM-1 to 0.

## Timing
- Reset values (asynchronous): state = IDLE, rr_ptr = 0, gnt_idx = 0, addr_q = 0, hit_q = 0. Outputs ack = 0, ack_hit = 0, destroyed = 0, busy = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- All outputs are registered or Moore-decoded from state and registers. No combinational path from req to any output.
- Latency, in-range request: req sampled at edge t (IDLE) -> mem_en in cycle t+1 -> mem_we in cycle t+2 -> ack in cycle t+3. Throughput is one transaction per 4 cycles.
- Latency, out-of-range request: ack in cycle t+1, with no RAM activity.
- Reset asserted mid-transaction aborts immediately: no pending write completes and no ack is issued. The requester re-requests after reset.

## Structure
- Shared package: FSM state encoding (2 bits), BRICK_NUM, ADDR_W, STR_W, and the empty-strength constant 0. The game controller and brick renderer use the same constants.
- One sub-module, rr_arbiter: combinational round-robin picker with inputs req and rr_ptr, outputs gnt_valid and gnt_idx, parameterised by BALL_NUM.
- The FSM, registers and RAM port drive stay in brick_arbiter.

## Test plan
- Single hit: RAM[5] = 2; ball 0 requests addr 5 -> mem_en at t+1, mem_we with wdata 1 at t+2, ack = 001 and ack_hit = 1 at t+3, destroyed = 0. RAM[5] reads 1 afterwards.
- Destroy: RAM[9] = 1; ball 1 requests addr 9 -> ack = 010, ack_hit = 1, destroyed pulses for 1 cycle, RAM[9] = 0. A repeat request gets ack_hit = 0 and no mem_we.
- Contention: all three balls request together from reset (rr_ptr = 0) -> acks in order 001, 010, 100, spaced 4 cycles apart. Ball 0 re-requests at once -> it is served after ball 2.
- Out of range: ball 2 requests addr 127 with BRICK_NUM = 120 -> ack = 100 and ack_hit = 0 at t+1. mem_en and mem_we stay 0 throughout.
- Reset mid-op: assert reset during CHECK -> all outputs 0 in the same cycle, the RAM is unmodified, and the state returns to IDLE.
- Withdrawal: ball 1 raises req for 0 cycles at an IDLE edge (glitch between edges) -> no grant, busy stays 0.
